// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
//   FIFO sequencer in front of a single-port 8x8 register-file memory.
//   It arbitrates between independent push and pop requests and issues at
//   most one memory access per cycle. Popped data comes back two cycles
//   after the pop grant.
//
// Ports
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   push, push_data      : write request and its data
//   push_ready           : push granted this cycle (combinational)
//   pop                  : read request
//   pop_ready            : pop granted this cycle (combinational)
//   pop_valid, pop_data  : popped word, valid two cycles after the grant
//   mem_write_en, mem_read_en, mem_address, mem_data_in : memory controls
//   mem_data_out         : registered read data from the memory
//   count, full, empty   : occupancy and its decoded flags
module mem_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              last_served;  // 1 = the most recent grant was a push
  logic              rd_pend;
  logic              push_legal;
  logic              pop_legal;
  logic              grant_push;
  logic              grant_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Requests are masked during reset so nothing is granted while the
  // state is being held cleared.
  assign push_legal = push && !full  && !reset;
  assign pop_legal  = pop  && !empty && !reset;

  // Under contention the side not served last wins, which alternates grants.
  assign grant_pop  = pop_legal  && (!push_legal ||  last_served);
  assign grant_push = push_legal && (!pop_legal  || !last_served);

  assign push_ready   = grant_push;
  assign pop_ready    = grant_pop;
  assign mem_write_en = grant_push;
  assign mem_read_en  = grant_pop;
  assign mem_address  = grant_push ? wr_ptr : rd_ptr;
  assign mem_data_in  = push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_served <= 1'b1;
      rd_pend     <= 1'b0;
      pop_valid   <= 1'b0;
      pop_data    <= '0;
    end else begin
      if (grant_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (grant_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (grant_push || grant_pop)
        last_served <= grant_push;
      // Stage 1: memory has latched the read word; mark it pending.
      rd_pend <= grant_pop;
      // Stage 2: capture the memory output; valid is presented next cycle.
      pop_valid <= rd_pend;
      if (rd_pend)
        pop_data <= mem_data_out;
    end
  end

endmodule
